// File: rtl/uart_tx_arbiter.sv
// Round-robin arbiter sharing one UART transmitter among NUM_REQ byte streams.
// A granted requester keeps the transmitter until its "last" byte has gone out.
module uart_tx_arbiter #(
  parameter int unsigned NUM_REQ      = 4,
  parameter int unsigned IDX_W        = 2,
  parameter int unsigned BUSY_TIMEOUT = 15
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic [NUM_REQ-1:0]   req_valid,
  input  logic [8*NUM_REQ-1:0] req_data,
  input  logic [NUM_REQ-1:0]   req_last,
  output logic [NUM_REQ-1:0]   req_ready,
  output logic                 uart_transmit,
  output logic [7:0]           uart_tx_byte,
  input  logic                 uart_is_transmitting,
  output logic [IDX_W-1:0]     grant_id,
  output logic                 locked,
  output logic                 timeout_err
);

  localparam logic [1:0] IDLE      = 2'd0;
  localparam logic [1:0] LAUNCH    = 2'd1;
  localparam logic [1:0] WAIT_BUSY = 2'd2;
  localparam logic [1:0] WAIT_DONE = 2'd3;

  localparam logic [7:0]       TIMEOUT_LIM = 8'(BUSY_TIMEOUT);
  localparam logic [IDX_W-1:0] LAST_IDX    = IDX_W'(NUM_REQ - 1);

  logic [1:0]       state;
  logic [IDX_W-1:0] rr_ptr;
  logic [IDX_W-1:0] pick_idx;
  logic [IDX_W-1:0] sel_idx;
  logic [IDX_W-1:0] next_ptr;
  logic             pick_found;
  logic             sel_valid;
  logic             grant;
  logic [7:0]       hold_byte;
  logic             hold_last;
  logic [7:0]       busy_cnt;
  logic [7:0]       cnt_inc;

  // First valid requester at or after rr_ptr, wrapping modulo NUM_REQ.
  always_comb begin : rr_search
    int unsigned cand;
    pick_found = 1'b0;
    pick_idx   = '0;
    cand       = 0;
    for (int unsigned i = 0; i < NUM_REQ; i++) begin
      cand = (32'(rr_ptr) + i) % NUM_REQ;
      if (!pick_found && req_valid[IDX_W'(cand)]) begin
        pick_found = 1'b1;
        pick_idx   = IDX_W'(cand);
      end
    end
  end

  // While locked only the current owner may be served.
  always_comb begin
    sel_idx   = locked ? grant_id : pick_idx;
    sel_valid = locked ? req_valid[grant_id] : pick_found;
    grant     = (state == IDLE) && !uart_is_transmitting && sel_valid && !rst;
    req_ready = grant ? (NUM_REQ'(1) << sel_idx) : '0;
    next_ptr  = (grant_id == LAST_IDX) ? '0 : grant_id + 1'b1;
    cnt_inc   = (busy_cnt == 8'hFF) ? busy_cnt : busy_cnt + 8'd1;
  end

  assign uart_transmit = (state == LAUNCH);
  assign uart_tx_byte  = hold_byte;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state       <= IDLE;
      rr_ptr      <= '0;
      grant_id    <= '0;
      locked      <= 1'b0;
      hold_byte   <= '0;
      hold_last   <= 1'b0;
      busy_cnt    <= '0;
      timeout_err <= 1'b0;
    end else begin
      timeout_err <= 1'b0;
      case (state)
        IDLE: begin
          if (grant) begin
            hold_byte <= req_data[{sel_idx, 3'b000} +: 8];
            hold_last <= req_last[sel_idx];
            grant_id  <= sel_idx;
            locked    <= 1'b1;
            state     <= LAUNCH;
          end
        end
        LAUNCH: begin
          busy_cnt <= '0;
          state    <= WAIT_BUSY;
        end
        WAIT_BUSY: begin
          if (uart_is_transmitting) begin
            state <= WAIT_DONE;
          end else begin
            busy_cnt <= cnt_inc;
            // Byte is dropped on timeout; the packet lock is released.
            if (cnt_inc >= TIMEOUT_LIM) begin
              timeout_err <= 1'b1;
              locked      <= 1'b0;
              rr_ptr      <= next_ptr;
              state       <= IDLE;
            end
          end
        end
        WAIT_DONE: begin
          if (!uart_is_transmitting) begin
            state <= IDLE;
            if (hold_last) begin
              locked <= 1'b0;
              rr_ptr <= next_ptr;
            end
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_uart_tx_arbiter.sv
// Scoreboard bench for uart_tx_arbiter with a simple transmitter busy model.
module tb_uart_tx_arbiter;

  localparam int unsigned NUM_REQ      = 4;
  localparam int unsigned IDX_W        = 2;
  localparam int unsigned BUSY_TIMEOUT = 15;

  logic                 clk = 1'b0;
  logic                 rst = 1'b1;
  logic [NUM_REQ-1:0]   req_valid;
  logic [8*NUM_REQ-1:0] req_data;
  logic [NUM_REQ-1:0]   req_last;
  logic [NUM_REQ-1:0]   req_ready;
  logic                 uart_transmit;
  logic [7:0]           uart_tx_byte;
  logic                 uart_is_transmitting;
  logic [IDX_W-1:0]     grant_id;
  logic                 locked;
  logic                 timeout_err;

  logic                 ext_busy;
  logic                 model_resp;
  int unsigned          mbusy;
  int unsigned          frame_len;
  logic [8:0]           src_q[NUM_REQ][$];
  logic [IDX_W+7:0]     sb[$];
  logic [NUM_REQ-1:0]   rdy_s;
  logic                 prev_tx;
  int unsigned          cyc;
  int unsigned          t_launch;
  int                   n_cmp;
  int                   n_bad;

  assign uart_is_transmitting = ext_busy | (mbusy != 0);

  always #5 clk = ~clk;

  uart_tx_arbiter #(
    .NUM_REQ(NUM_REQ),
    .IDX_W(IDX_W),
    .BUSY_TIMEOUT(BUSY_TIMEOUT)
  ) dut (
    .clk(clk),
    .rst(rst),
    .req_valid(req_valid),
    .req_data(req_data),
    .req_last(req_last),
    .req_ready(req_ready),
    .uart_transmit(uart_transmit),
    .uart_tx_byte(uart_tx_byte),
    .uart_is_transmitting(uart_is_transmitting),
    .grant_id(grant_id),
    .locked(locked),
    .timeout_err(timeout_err)
  );

  // One clock: advance sources after the edge, then observe at the falling edge.
  task automatic tick();
    logic [IDX_W+7:0] exp;
    @(posedge clk);
    #1;
    cyc++;
    for (int i = 0; i < NUM_REQ; i++) begin
      if (rdy_s[i] && src_q[i].size() > 0) void'(src_q[i].pop_front());
      if (src_q[i].size() > 0) begin
        req_valid[i]      = 1'b1;
        req_data[8*i +: 8] = src_q[i][0][7:0];
        req_last[i]       = src_q[i][0][8];
      end else begin
        req_valid[i]      = 1'b0;
        req_data[8*i +: 8] = 8'h00;
        req_last[i]       = 1'b0;
      end
    end
    @(negedge clk);
    if (req_ready != '0) begin
      n_cmp++;
      if ($countones(req_ready) != 1) begin
        n_bad++;
        $display("FAIL ready_onehot: got %b, required exactly one bit set", req_ready);
      end
    end
    if (uart_transmit) begin
      n_cmp++;
      if (prev_tx) begin
        n_bad++;
        $display("FAIL transmit_pulse: got 2+ consecutive cycles, required 1");
      end
      n_cmp++;
      if (mbusy != 0) begin
        n_bad++;
        $display("FAIL launch_overlap: got launch while busy (%0d left), required idle", mbusy);
      end
      n_cmp++;
      if (sb.size() == 0) begin
        n_bad++;
        $display("FAIL launch_unexpected: got id %0d byte %h, required no launch", grant_id, uart_tx_byte);
      end else begin
        exp = sb.pop_front();
        if ({grant_id, uart_tx_byte} !== exp) begin
          n_bad++;
          $display("FAIL launch_data: got id %0d byte %h, required id %0d byte %h",
                   grant_id, uart_tx_byte, exp[IDX_W+7:8], exp[7:0]);
        end
      end
      t_launch = cyc;
      mbusy    = model_resp ? frame_len : 0;
    end else if (mbusy != 0) begin
      mbusy--;
    end
    prev_tx = uart_transmit;
    rdy_s   = req_ready;
  endtask

  task automatic clear_bench();
    for (int i = 0; i < NUM_REQ; i++) src_q[i].delete();
    sb.delete();
    mbusy   = 0;
    rdy_s   = '0;
    prev_tx = 1'b0;
  endtask

  task automatic test_reset();
    rst        = 1'b1;
    ext_busy   = 1'b0;
    model_resp = 1'b1;
    frame_len  = 8;
    req_valid  = '0;
    req_data   = '0;
    req_last   = '0;
    clear_bench();
    repeat (2) tick();
    n_cmp++;
    if ({req_ready, uart_transmit, uart_tx_byte, grant_id, locked, timeout_err} !== '0) begin
      n_bad++;
      $display("FAIL reset_outputs: got ready=%b tx=%b byte=%h id=%0d lock=%b to=%b, required all 0",
               req_ready, uart_transmit, uart_tx_byte, grant_id, locked, timeout_err);
    end
    n_cmp++;
    if (dut.rr_ptr !== 2'd0) begin
      n_bad++;
      $display("FAIL reset_rr_ptr: got %0d, required 0", dut.rr_ptr);
    end
    rst = 1'b0;
  endtask

  task automatic test_single();
    test_reset();
    frame_len = 40;
    src_q[0].push_back({1'b1, 8'h55});
    sb.push_back({2'd0, 8'h55});
    for (int k = 0; k < 5 && !req_valid[0]; k++) tick();
    n_cmp++;
    if (req_ready !== 4'b0001) begin
      n_bad++;
      $display("FAIL single_ready: got %b, required 0001 in the first valid cycle", req_ready);
    end
    tick();
    n_cmp++;
    if ({uart_transmit, uart_tx_byte, locked} !== {1'b1, 8'h55, 1'b1}) begin
      n_bad++;
      $display("FAIL single_launch: got tx=%b byte=%h lock=%b, required 1 55 1",
               uart_transmit, uart_tx_byte, locked);
    end
    for (int k = 0; k < 100 && locked; k++) tick();
    n_cmp++;
    if (locked !== 1'b0 || (cyc - t_launch) !== frame_len + 1) begin
      n_bad++;
      $display("FAIL single_unlock: got lock=%b after %0d cycles, required 0 after %0d",
               locked, cyc - t_launch, frame_len + 1);
    end
    n_cmp++;
    if (dut.rr_ptr !== 2'd1 || grant_id !== 2'd0) begin
      n_bad++;
      $display("FAIL single_ptr: got rr_ptr=%0d id=%0d, required 1 0", dut.rr_ptr, grant_id);
    end
  endtask

  task automatic test_round_robin();
    test_reset();
    for (int i = 0; i < NUM_REQ; i++) begin
      src_q[i].push_back({1'b1, 8'(8'hA0 + i)});
      sb.push_back({2'(i), 8'(8'hA0 + i)});
    end
    src_q[0].push_back({1'b1, 8'hA4});
    sb.push_back({2'd0, 8'hA4});
    for (int k = 0; k < 2000 && (sb.size() != 0 || locked || uart_is_transmitting); k++) tick();
    n_cmp++;
    if (sb.size() != 0 || locked) begin
      n_bad++;
      $display("FAIL rr_drain: got %0d launches outstanding lock=%b, required 0 0", sb.size(), locked);
    end
  endtask

  task automatic test_packet_lock();
    test_reset();
    src_q[0].push_back({1'b0, 8'h10});
    src_q[0].push_back({1'b0, 8'h11});
    src_q[0].push_back({1'b1, 8'h12});
    src_q[1].push_back({1'b1, 8'h20});
    sb.push_back({2'd0, 8'h10});
    sb.push_back({2'd0, 8'h11});
    sb.push_back({2'd0, 8'h12});
    sb.push_back({2'd1, 8'h20});
    for (int k = 0; k < 2000 && (sb.size() != 0 || locked || uart_is_transmitting); k++) begin
      tick();
      if (req_ready[1]) begin
        n_cmp++;
        if (sb.size() != 1) begin
          n_bad++;
          $display("FAIL lock_hold: got req1 ready with %0d launches pending, required 1", sb.size());
        end
      end
    end
    n_cmp++;
    if (sb.size() != 0 || locked) begin
      n_bad++;
      $display("FAIL lock_drain: got %0d launches outstanding lock=%b, required 0 0", sb.size(), locked);
    end
  endtask

  task automatic test_timeout();
    test_reset();
    model_resp = 1'b0;
    src_q[0].push_back({1'b0, 8'h30});
    src_q[1].push_back({1'b1, 8'h31});
    sb.push_back({2'd0, 8'h30});
    sb.push_back({2'd1, 8'h31});
    for (int k = 0; k < 60 && !timeout_err; k++) tick();
    n_cmp++;
    if (timeout_err !== 1'b1 || (cyc - t_launch) !== 1 + BUSY_TIMEOUT) begin
      n_bad++;
      $display("FAIL timeout_time: got err=%b at %0d cycles after launch, required 1 at %0d",
               timeout_err, cyc - t_launch, 1 + BUSY_TIMEOUT);
    end
    n_cmp++;
    if (locked !== 1'b0 || req_ready !== 4'b0010) begin
      n_bad++;
      $display("FAIL timeout_release: got lock=%b ready=%b, required 0 0010", locked, req_ready);
    end
    tick();
    n_cmp++;
    if (timeout_err !== 1'b0) begin
      n_bad++;
      $display("FAIL timeout_pulse: got err=%b one cycle later, required 0", timeout_err);
    end
    for (int k = 0; k < 60 && !timeout_err; k++) tick();
    n_cmp++;
    if ({timeout_err, locked, grant_id, dut.rr_ptr} !== {1'b1, 1'b0, 2'd1, 2'd2}) begin
      n_bad++;
      $display("FAIL timeout_second: got err=%b lock=%b id=%0d rr_ptr=%0d, required 1 0 1 2",
               timeout_err, locked, grant_id, dut.rr_ptr);
    end
    n_cmp++;
    if (sb.size() != 0) begin
      n_bad++;
      $display("FAIL timeout_drain: got %0d launches outstanding, required 0", sb.size());
    end
    model_resp = 1'b1;
  endtask

  task automatic test_ext_busy();
    logic seen;
    test_reset();
    ext_busy = 1'b1;
    seen     = 1'b0;
    src_q[2].push_back({1'b1, 8'h42});
    sb.push_back({2'd2, 8'h42});
    repeat (6) begin
      tick();
      if (req_ready != '0) seen = 1'b1;
    end
    n_cmp++;
    if (seen || req_valid[2] !== 1'b1) begin
      n_bad++;
      $display("FAIL ext_busy_hold: got ready_seen=%b valid=%b, required 0 1", seen, req_valid[2]);
    end
    ext_busy = 1'b0;
    #1;
    n_cmp++;
    if (req_ready !== 4'b0100) begin
      n_bad++;
      $display("FAIL ext_busy_grant: got %b, required 0100 on first idle cycle", req_ready);
    end
    rdy_s = req_ready;
    for (int k = 0; k < 200 && (sb.size() != 0 || locked || uart_is_transmitting); k++) tick();
    n_cmp++;
    if (sb.size() != 0 || locked) begin
      n_bad++;
      $display("FAIL ext_busy_drain: got %0d outstanding lock=%b, required 0 0", sb.size(), locked);
    end
  endtask

  task automatic test_async_reset();
    test_reset();
    frame_len = 30;
    src_q[1].push_back({1'b1, 8'h5A});
    sb.push_back({2'd1, 8'h5A});
    for (int k = 0; k < 200 && (sb.size() != 0 || locked || uart_is_transmitting); k++) tick();
    src_q[0].push_back({1'b0, 8'h60});
    src_q[0].push_back({1'b1, 8'h61});
    sb.push_back({2'd0, 8'h60});
    for (int k = 0; k < 20 && sb.size() != 0; k++) tick();
    repeat (4) tick();
    n_cmp++;
    if ({locked, uart_is_transmitting, req_valid[0]} !== 3'b111) begin
      n_bad++;
      $display("FAIL areset_pre: got lock=%b busy=%b valid0=%b, required 1 1 1",
               locked, uart_is_transmitting, req_valid[0]);
    end
    #2;
    rst = 1'b1;
    #1;
    n_cmp++;
    if ({req_ready, uart_transmit, uart_tx_byte, grant_id, locked, timeout_err} !== '0) begin
      n_bad++;
      $display("FAIL areset_outputs: got ready=%b tx=%b byte=%h id=%0d lock=%b to=%b, required all 0",
               req_ready, uart_transmit, uart_tx_byte, grant_id, locked, timeout_err);
    end
    clear_bench();
    repeat (2) tick();
    rst = 1'b0;
    src_q[3].push_back({1'b1, 8'h73});
    src_q[1].push_back({1'b1, 8'h71});
    sb.push_back({2'd1, 8'h71});
    sb.push_back({2'd3, 8'h73});
    for (int k = 0; k < 500 && (sb.size() != 0 || locked || uart_is_transmitting); k++) tick();
    n_cmp++;
    if (sb.size() != 0 || locked) begin
      n_bad++;
      $display("FAIL areset_restart: got %0d outstanding lock=%b, required 0 0", sb.size(), locked);
    end
  endtask

  initial begin
    n_cmp    = 0;
    n_bad    = 0;
    cyc      = 0;
    t_launch = 0;
    test_reset();
    test_single();
    test_round_robin();
    test_packet_lock();
    test_timeout();
    test_ext_busy();
    test_async_reset();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
